// File: rtl/rvfi_reg_tracer.sv
// RVFI trace source: turns a per-lane instruction feed into a register-consistent
// RVFI stream backed by a shadow register file, with optional single-shot rs1 corruption.
module rvfi_reg_tracer #(
   parameter int XLEN = 32,
   parameter int NRET = 1
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [NRET-1:0]      in_valid,
   input  logic [5*NRET-1:0]    in_rs1_addr,
   input  logic [5*NRET-1:0]    in_rs2_addr,
   input  logic [5*NRET-1:0]    in_rd_addr,
   input  logic [XLEN*NRET-1:0] in_rd_wdata,
   input  logic                 fault_en,
   input  logic [4:0]           fault_reg,
   output logic [NRET-1:0]      rvfi_valid,
   output logic [64*NRET-1:0]   rvfi_order,
   output logic [5*NRET-1:0]    rvfi_rs1_addr,
   output logic [5*NRET-1:0]    rvfi_rs2_addr,
   output logic [5*NRET-1:0]    rvfi_rd_addr,
   output logic [XLEN*NRET-1:0] rvfi_rs1_rdata,
   output logic [XLEN*NRET-1:0] rvfi_rs2_rdata,
   output logic [XLEN*NRET-1:0] rvfi_rd_wdata,
   output logic                 fault_fired,
   output logic [1:0]           fault_state
);

   // Handshake: valid-only, no ready. Every lane in the contiguous in_valid prefix is
   // accepted at the edge and appears on rvfi_* one cycle later with rvfi_valid set.

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_FIRED = 2'd2;

   logic [XLEN-1:0] regs [32];
   logic [63:0]     next_order;
   logic [1:0]      state;
   logic [4:0]      armed_reg;

   logic [NRET-1:0] lane_v;
   logic [NRET-1:0] fire_vec;
   logic            fire;
   logic [63:0]     n_ret;
   logic [XLEN-1:0] rs1_d [NRET];
   logic [XLEN-1:0] rs2_d [NRET];

   always_comb begin
      logic            run;
      logic [4:0]      rs1_a;
      logic [4:0]      rs2_a;
      logic [4:0]      rd_j;
      run      = 1'b1;
      fire     = 1'b0;
      fire_vec = '0;
      n_ret    = '0;
      lane_v   = '0;
      for (int k = 0; k < NRET; k++) begin
         run       = run & in_valid[k];
         lane_v[k] = run;
         n_ret     = n_ret + 64'(run);
         rs1_a     = in_rs1_addr[5*k +: 5];
         rs2_a     = in_rs2_addr[5*k +: 5];
         rs1_d[k]  = (rs1_a == 5'd0) ? '0 : regs[rs1_a];
         rs2_d[k]  = (rs2_a == 5'd0) ? '0 : regs[rs2_a];
         // Forward from earlier lanes; the later lane in the scan overrides, so highest j<k wins.
         for (int j = 0; j < k; j++) begin
            rd_j = in_rd_addr[5*j +: 5];
            if (lane_v[j] && rd_j != 5'd0 && rd_j == rs1_a) rs1_d[k] = in_rd_wdata[XLEN*j +: XLEN];
            if (lane_v[j] && rd_j != 5'd0 && rd_j == rs2_a) rs2_d[k] = in_rd_wdata[XLEN*j +: XLEN];
         end
         if (state == ST_ARMED && !fire && run && rs1_a == armed_reg && rs1_a != 5'd0) begin
            fire        = 1'b1;
            fire_vec[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int r = 0; r < 32; r++) regs[r] <= '0;
         next_order     <= '0;
         state          <= ST_IDLE;
         armed_reg      <= '0;
         rvfi_valid     <= '0;
         rvfi_order     <= '0;
         rvfi_rs1_addr  <= '0;
         rvfi_rs2_addr  <= '0;
         rvfi_rd_addr   <= '0;
         rvfi_rs1_rdata <= '0;
         rvfi_rs2_rdata <= '0;
         rvfi_rd_wdata  <= '0;
         fault_fired    <= 1'b0;
      end else begin
         for (int k = 0; k < NRET; k++) begin
            rvfi_valid[k]                  <= lane_v[k];
            rvfi_order[64*k +: 64]         <= lane_v[k] ? next_order + 64'(k) : 64'd0;
            rvfi_rs1_addr[5*k +: 5]        <= lane_v[k] ? in_rs1_addr[5*k +: 5] : 5'd0;
            rvfi_rs2_addr[5*k +: 5]        <= lane_v[k] ? in_rs2_addr[5*k +: 5] : 5'd0;
            rvfi_rd_addr[5*k +: 5]         <= lane_v[k] ? in_rd_addr[5*k +: 5] : 5'd0;
            rvfi_rs1_rdata[XLEN*k +: XLEN] <= lane_v[k] ? (rs1_d[k] ^ XLEN'(fire_vec[k])) : '0;
            rvfi_rs2_rdata[XLEN*k +: XLEN] <= lane_v[k] ? rs2_d[k] : '0;
            rvfi_rd_wdata[XLEN*k +: XLEN]  <= (lane_v[k] && in_rd_addr[5*k +: 5] != 5'd0)
                                              ? in_rd_wdata[XLEN*k +: XLEN] : '0;
            // Later lanes are assigned last, so the highest lane wins on a duplicate rd.
            if (lane_v[k] && in_rd_addr[5*k +: 5] != 5'd0)
               regs[in_rd_addr[5*k +: 5]] <= in_rd_wdata[XLEN*k +: XLEN];
         end
         next_order  <= next_order + n_ret;
         fault_fired <= fire;
         case (state)
            ST_IDLE: if (fault_en) begin
               state     <= ST_ARMED;
               armed_reg <= fault_reg;
            end
            ST_ARMED: if (fire) state <= ST_FIRED;
            ST_FIRED: if (!fault_en) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign fault_state = state;

endmodule

// File: tb/tb_rvfi_reg_tracer.sv
// Bench for rvfi_reg_tracer (XLEN=32, NRET=2): directed vector table with hand-derived
// spot values, wrap and mid-stream reset sequences, and a random phase against a lane-serial model.
module tb_rvfi_reg_tracer;
   localparam int XLEN = 32;
   localparam int NRET = 2;
   localparam int W    = 2 + NRET * (1 + 64 + 15 + 3 * XLEN) + 1;

   logic                 clock = 1'b0;
   logic                 resetn;
   logic [NRET-1:0]      in_valid;
   logic [5*NRET-1:0]    in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic [XLEN*NRET-1:0] in_rd_wdata;
   logic                 fault_en;
   logic [4:0]           fault_reg;
   logic [NRET-1:0]      rvfi_valid;
   logic [64*NRET-1:0]   rvfi_order;
   logic [5*NRET-1:0]    rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
   logic [XLEN*NRET-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
   logic                 fault_fired;
   logic [1:0]           fault_state;

   always #5 clock = ~clock;

   rvfi_reg_tracer #(.XLEN(XLEN), .NRET(NRET)) dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
      .in_rd_wdata(in_rd_wdata), .fault_en(fault_en), .fault_reg(fault_reg),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
      .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
      .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
      .rvfi_rd_wdata(rvfi_rd_wdata), .fault_fired(fault_fired), .fault_state(fault_state)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  v;
      logic [4:0]  rs1a, rs2a, rda, rs1b, rs2b, rdb;
      logic [31:0] wda, wdb;
      logic        fen;
      logic [4:0]  freg;
      int          lane;
      logic [63:0] e_order, e_rs1, e_rs2, e_wd;
      logic        e_fired;
   } vec_t;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   logic [XLEN-1:0] m_regs [32];
   logic [63:0]     m_order;
   logic [1:0]      m_state;
   logic [4:0]      m_freg;

   function automatic vec_t mk(logic rst, logic [1:0] v,
                               logic [4:0] rs1a, logic [4:0] rs2a, logic [4:0] rda, logic [31:0] wda,
                               logic [4:0] rs1b, logic [4:0] rs2b, logic [4:0] rdb, logic [31:0] wdb,
                               logic fen, logic [4:0] freg, int lane,
                               logic [63:0] eo, logic [63:0] er1, logic [63:0] er2,
                               logic [63:0] ewd, logic ef);
      vec_t r;
      r.rst = rst; r.v = v; r.rs1a = rs1a; r.rs2a = rs2a; r.rda = rda; r.wda = wda;
      r.rs1b = rs1b; r.rs2b = rs2b; r.rdb = rdb; r.wdb = wdb; r.fen = fen; r.freg = freg;
      r.lane = lane; r.e_order = eo; r.e_rs1 = er1; r.e_rs2 = er2; r.e_wd = ewd; r.e_fired = ef;
      return r;
   endfunction

   // Lane-serial reference: each lane reads then writes the model file in order.
   task automatic predict();
      logic [NRET-1:0]      ev = '0;
      logic [64*NRET-1:0]   eo = '0;
      logic [5*NRET-1:0]    e1a = '0, e2a = '0, eda = '0;
      logic [XLEN*NRET-1:0] e1d = '0, e2d = '0, ewd = '0;
      logic                 fired = 1'b0;
      logic [4:0]           a1, a2, ad;
      logic [XLEN-1:0]      d1, d2, wd;
      int                   cnt = 0;
      if (!resetn) begin
         for (int r = 0; r < 32; r++) m_regs[r] = '0;
         m_order = '0; m_state = 2'd0; m_freg = '0;
         exp_q.push_back('0);
         return;
      end
      for (int k = 0; k < NRET; k++) begin
         if (!in_valid[k]) break;
         a1 = in_rs1_addr[5*k +: 5]; a2 = in_rs2_addr[5*k +: 5]; ad = in_rd_addr[5*k +: 5];
         d1 = (a1 == 0) ? '0 : m_regs[a1];
         d2 = (a2 == 0) ? '0 : m_regs[a2];
         if (m_state == 2'd1 && !fired && a1 == m_freg && a1 != 0) begin
            d1 = d1 ^ 1;
            fired = 1'b1;
         end
         wd = (ad == 0) ? '0 : in_rd_wdata[XLEN*k +: XLEN];
         if (ad != 0) m_regs[ad] = wd;
         ev[k] = 1'b1;
         eo[64*k +: 64] = m_order + 64'(k);
         e1a[5*k +: 5] = a1; e2a[5*k +: 5] = a2; eda[5*k +: 5] = ad;
         e1d[XLEN*k +: XLEN] = d1; e2d[XLEN*k +: XLEN] = d2; ewd[XLEN*k +: XLEN] = wd;
         cnt++;
      end
      m_order = m_order + 64'(cnt);
      case (m_state)
         2'd0: if (fault_en) begin m_state = 2'd1; m_freg = fault_reg; end
         2'd1: if (fired) m_state = 2'd2;
         default: if (!fault_en) m_state = 2'd0;
      endcase
      exp_q.push_back({m_state, ev, eo, e1a, e2a, eda, e1d, e2d, ewd, fired});
   endtask

   task automatic spot(string name, logic [63:0] got, logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic apply_row(vec_t r, string name);
      logic [W-1:0] obs, exp;
      @(negedge clock);
      resetn = r.rst; in_valid = r.v;
      in_rs1_addr = {r.rs1b, r.rs1a}; in_rs2_addr = {r.rs2b, r.rs2a}; in_rd_addr = {r.rdb, r.rda};
      in_rd_wdata = {r.wdb, r.wda}; fault_en = r.fen; fault_reg = r.freg;
      predict();
      @(posedge clock);
      #1;
      obs = {fault_state, rvfi_valid, rvfi_order, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
             rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, fault_fired};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no expected record queued", name);
      end else begin
         exp = exp_q.pop_front();
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, obs, exp);
         end
      end
      if (r.lane >= 0) begin
         spot({name, ".order"}, rvfi_order[64*r.lane +: 64], r.e_order);
         spot({name, ".rs1"}, 64'(rvfi_rs1_rdata[XLEN*r.lane +: XLEN]), r.e_rs1);
         spot({name, ".rs2"}, 64'(rvfi_rs2_rdata[XLEN*r.lane +: XLEN]), r.e_rs2);
         spot({name, ".wd"}, 64'(rvfi_rd_wdata[XLEN*r.lane +: XLEN]), r.e_wd);
         spot({name, ".fired"}, 64'(fault_fired), 64'(r.e_fired));
      end
   endtask

   vec_t tbl [17];

   initial begin
      resetn = 1'b0; in_valid = '0; in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
      in_rd_wdata = '0; fault_en = 1'b0; fault_reg = '0;
      //            rst v     rs1a rs2a rda wda           rs1b rs2b rdb wdb  fen freg lane order rs1   rs2  wd            fired
      tbl[0]  = mk(0, 2'b01, 0, 0, 5, 32'h1234,    0, 0, 0, 0, 1, 5, 0, 0,  0,     0,    0,            0);
      tbl[1]  = mk(1, 2'b01, 0, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0,    64'hDEADBEEF, 0);
      tbl[2]  = mk(1, 2'b01, 5, 0, 0, 32'h0,       0, 0, 0, 0, 0, 0, 0, 1,  64'hDEADBEEF, 0, 0,        0);
      tbl[3]  = mk(0, 2'b00, 0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 0, 0, 0,  0,     0,    0,            0);
      tbl[4]  = mk(1, 2'b11, 0, 0, 3, 32'h7,       3, 0, 0, 0, 0, 0, 1, 1,  7,     0,    0,            0);
      tbl[5]  = mk(1, 2'b01, 0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 0, 0, 2,  0,     0,    0,            0);
      tbl[6]  = mk(1, 2'b11, 0, 0, 9, 32'h1,       0, 0, 9, 2, 0, 0, 1, 4,  0,     0,    2,            0);
      tbl[7]  = mk(1, 2'b01, 9, 9, 0, 32'h0,       0, 0, 0, 0, 0, 0, 0, 5,  2,     2,    0,            0);
      tbl[8]  = mk(1, 2'b01, 0, 0, 0, 32'h55,      0, 0, 0, 0, 0, 0, 0, 6,  0,     0,    0,            0);
      tbl[9]  = mk(1, 2'b01, 0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 0, 0, 7,  0,     0,    0,            0);
      tbl[10] = mk(1, 2'b01, 0, 0, 4, 32'h10,      0, 0, 0, 0, 0, 0, 0, 8,  0,     0,    64'h10,       0);
      tbl[11] = mk(1, 2'b01, 4, 0, 0, 32'h0,       0, 0, 0, 0, 1, 4, 0, 9,  64'h10, 0,   0,            0);
      tbl[12] = mk(1, 2'b01, 4, 0, 0, 32'h0,       0, 0, 0, 0, 1, 4, 0, 10, 64'h11, 0,   0,            1);
      tbl[13] = mk(1, 2'b01, 4, 0, 0, 32'h0,       0, 0, 0, 0, 1, 4, 0, 11, 64'h10, 0,   0,            0);
      tbl[14] = mk(1, 2'b01, 4, 0, 0, 32'h0,       0, 0, 0, 0, 0, 0, 0, 12, 64'h10, 0,   0,            0);
      tbl[15] = mk(1, 2'b10, 0, 0, 0, 32'h0,       4, 4, 6, 9, 0, 0, 1, 0,  0,     0,    0,            0);
      tbl[16] = mk(1, 2'b11, 4, 0, 4, 32'h20,      4, 4, 0, 0, 0, 0, 1, 14, 64'h20, 64'h20, 0,         0);
      for (int i = 0; i < 17; i++) apply_row(tbl[i], $sformatf("row%0d", i));

      // Counter wrap: preload the order counter with all ones between edges.
      #1;
      force dut.next_order = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.next_order;
      m_order = 64'hFFFF_FFFF_FFFF_FFFF;
      apply_row(mk(1, 2'b01, 0, 0, 7, 32'hAB, 0, 0, 0, 0, 0, 0, 0,
                   64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'hAB, 0), "wrap_last");
      apply_row(mk(1, 2'b11, 7, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "wrap_next");

      // Reset in the middle of a write: the write is discarded and reads start from zero.
      apply_row(mk(0, 2'b01, 0, 0, 6, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mid_rst");
      apply_row(mk(1, 2'b01, 6, 9, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst");

      for (int i = 0; i < 80; i++) begin
         vec_t r;
         r = mk(($urandom_range(0, 39) != 0), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), -1, 0, 0, 0, 0, 0);
         apply_row(r, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
